// File: rtl/riscv_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_dmem_pkg
//  Description : Shared types and helpers for the RISC-V data-memory APB
//                master: FSM state encoding, access-size encoding and the
//                byte-strobe mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } dmem_size_t;

    // Widest strobe vector supported (DATA_W = 64).
    localparam int c_STRB_MAX_W = 8;

    // Strobe mask for an access of the given size starting at byte lane
    // 'lane'. Callers truncate to their own strobe width.
    function automatic logic [c_STRB_MAX_W-1:0] dmem_strb_mask(
        input dmem_size_t size,
        input logic [2:0] lane
    );
        logic [c_STRB_MAX_W-1:0] v_mask;
        case (size)
            SZ_B:    v_mask = 8'h01;
            SZ_H:    v_mask = 8'h03;
            SZ_W:    v_mask = 8'h0F;
            default: v_mask = 8'hFF;
        endcase
        return v_mask << lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_dmem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_dmem_lane
//  Description : Combinational byte-lane logic. Replicates store data across
//                all lanes, builds byte strobes, and extracts / extends load
//                data from the addressed lane.
//  Ports       : lane_i   - byte lane within the bus word
//                size_i   - access size (byte/half/word/double)
//                uns_i    - 1 zero-extends loads, 0 sign-extends
//                wdata_i  - right-justified store data
//                prdata_i - raw bus read data
//                pwdata_o - lane-steered store data
//                pstrb_o  - byte strobes
//                ldata_o  - aligned, extended load data
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_dmem_lane
    import riscv_dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] lane_i,
    input  dmem_size_t                  size_i,
    input  logic                        uns_i,
    input  logic [DATA_W-1:0]           wdata_i,
    input  logic [DATA_W-1:0]           prdata_i,
    output logic [DATA_W-1:0]           pwdata_o,
    output logic [DATA_W/8-1:0]         pstrb_o,
    output logic [DATA_W-1:0]           ldata_o
);

    logic [c_STRB_MAX_W-1:0] w_mask;
    logic [DATA_W-1:0]       w_shift;

    // Replicating the low bits across every lane means the slave sees the
    // correct byte whatever lane the strobes select.
    always_comb begin
        pwdata_o = wdata_i;
        case (size_i)
            SZ_B:    pwdata_o = {(DATA_W/8){wdata_i[7:0]}};
            SZ_H:    pwdata_o = {(DATA_W/16){wdata_i[15:0]}};
            SZ_W:    pwdata_o = {(DATA_W/32){wdata_i[31:0]}};
            default: pwdata_o = wdata_i;
        endcase
    end

    assign w_mask  = dmem_strb_mask(size_i, 3'(lane_i));
    assign pstrb_o = w_mask[DATA_W/8-1:0];

    assign w_shift = prdata_i >> {lane_i, 3'b000};

    // A size cast of a signed operand sign-extends, of an unsigned operand
    // zero-extends; this avoids zero-width replications when DATA_W = 32.
    always_comb begin
        ldata_o = w_shift;
        case (size_i)
            SZ_B: ldata_o = uns_i ? DATA_W'(w_shift[7:0])
                                  : DATA_W'($signed(w_shift[7:0]));
            SZ_H: ldata_o = uns_i ? DATA_W'(w_shift[15:0])
                                  : DATA_W'($signed(w_shift[15:0]));
            SZ_W: ldata_o = uns_i ? DATA_W'(w_shift[31:0])
                                  : DATA_W'($signed(w_shift[31:0]));
            default: ldata_o = w_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_apb.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_dmem_apb
//  Description : APB4 master for the core's data-memory port. Registers one
//                load/store per valid/ready handshake, drives a SETUP/ACCESS
//                APB transfer and returns a registered done/err pulse with
//                aligned, extended load data. Misaligned requests complete
//                with an error and no bus transfer.
//  Ports       : ex_dmem_*  - request from execute stage (valid/ready)
//                p*         - APB4 master interface
//                dmem_*     - registered completion (data, done, err)
//  Options     : DMEM_APB_TIMEOUT_EN - abort ACCESS after TIMEOUT_CYCLES
//                cycles with pready_i low.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_dmem_apb
    import riscv_dmem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_dmem_valid_i,
    output logic                ex_dmem_ready_o,
    input  logic [ADDR_W-1:0]   ex_dmem_addr_i,
    input  logic [DATA_W-1:0]   ex_dmem_wdata_i,
    input  logic                ex_dmem_wnr_i,
    input  logic [1:0]          ex_dmem_size_i,
    input  logic                ex_dmem_uns_i,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic [DATA_W/8-1:0] pstrb_o,
    output logic [2:0]          pprot_o,
    input  logic                pready_i,
    input  logic                pslverr_i,
    input  logic [DATA_W-1:0]   prdata_i,
    output logic [DATA_W-1:0]   dmem_data_o,
    output logic                dmem_done_o,
    output logic                dmem_err_o
);

    localparam int                c_LANE_W    = $clog2(DATA_W/8);
    localparam logic [ADDR_W-1:0] c_LANE_MASK = ADDR_W'(DATA_W/8-1);

    dmem_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wnr;
    dmem_size_t          r_size;
    logic                r_uns;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_data;

    logic                w_accept;
    logic                w_bad;
    logic [2:0]          w_align_mask;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_pwdata;
    logic [DATA_W-1:0]   w_ldata;
    logic [DATA_W/8-1:0] w_strb;

    assign w_accept = ex_dmem_valid_i && (r_state == ST_IDLE);

    // Misaligned when any address bit below the access size is set;
    // doublewords cannot be carried on a 32-bit bus at all.
    always_comb begin
        case (ex_dmem_size_i)
            2'd0:    w_align_mask = 3'b000;
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
        w_bad = (|(ex_dmem_addr_i[2:0] & w_align_mask)) ||
                ((ex_dmem_size_i == 2'd3) && (DATA_W == 32));
    end

`ifdef DMEM_APB_TIMEOUT_EN
    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo;

    // Cleared in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo <= '0;
        end else if (r_state == ST_SETUP) begin
            r_tmo <= '0;
        end else if ((r_state == ST_ACCESS) && !pready_i) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // This cycle would be the TIMEOUT_CYCLES-th wait; pready_i takes priority.
    assign w_timeout = (r_state == ST_ACCESS) && !pready_i && (r_tmo == c_TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and APB control
    always_comb begin
        w_state_nxt     = r_state;
        ex_dmem_ready_o = 1'b0;
        psel_o          = 1'b0;
        penable_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ex_dmem_ready_o = 1'b1;
                if (ex_dmem_valid_i) begin
                    w_state_nxt = w_bad ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_o      = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wnr   <= 1'b0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_done <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_addr  <= ex_dmem_addr_i;
                r_wdata <= ex_dmem_wdata_i;
                r_wnr   <= ex_dmem_wnr_i;
                r_size  <= dmem_size_t'(ex_dmem_size_i);
                r_uns   <= ex_dmem_uns_i;
                r_err   <= w_bad;
                if (w_bad) begin
                    r_data <= '0;
                end
            end else if (r_state == ST_ACCESS) begin
                if (pready_i) begin
                    r_err <= pslverr_i;
                    if (pslverr_i) begin
                        r_data <= '0;
                    end else if (!r_wnr) begin
                        r_data <= w_ldata;
                    end
                end else if (w_timeout) begin
                    r_err  <= 1'b1;
                    r_data <= '0;
                end
            end else if (r_state == ST_RESP) begin
                r_err <= 1'b0;
            end
        end
    end

    riscv_dmem_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .lane_i   (r_addr[c_LANE_W-1:0]),
        .size_i   (r_size),
        .uns_i    (r_uns),
        .wdata_i  (r_wdata),
        .prdata_i (prdata_i),
        .pwdata_o (w_pwdata),
        .pstrb_o  (w_strb),
        .ldata_o  (w_ldata)
    );

    assign paddr_o     = r_addr & ~c_LANE_MASK;
    assign pwdata_o    = w_pwdata;
    assign pstrb_o     = r_wnr ? w_strb : '0;
    assign pwrite_o    = r_wnr;
    assign pprot_o     = 3'b000;
    assign dmem_data_o = r_data;
    assign dmem_done_o = r_done;
    assign dmem_err_o  = r_err;

endmodule
`default_nettype wire
